// File: rtl/posit_pkg.sv
// Shared types for the posit datapath: the operand format selector and the
// classifier flag bundle that travels beside each posit word.
package posit_pkg;

    typedef enum logic [0:0] {
        POSIT32_ES2 = 1'b0
    } posit_format_e;

    typedef struct packed {
        logic is_zero;
        logic is_NaR;
        logic is_pos;
        logic is_neg;
    } posit_info_t;

endpackage

// File: rtl/posit_decoder_if.sv
// Handshake and data bundle of the posit decoder. The slave side is the decoder,
// and the master side is whoever feeds it and drains it.
interface posit_decoder_if #(
    parameter int NumOperands = 2,
    parameter int TagWidth    = 4
);

    logic [NumOperands-1:0][31:0]          operands_i;
    posit_pkg::posit_info_t [NumOperands-1:0] info_i;
    logic [TagWidth-1:0]                   tag_i;
    logic                                  in_valid_i;
    logic                                  in_ready_o;

    logic [NumOperands-1:0]                sign_o;
    logic [NumOperands-1:0][7:0]           scale_o;
    logic [NumOperands-1:0][27:0]          mant_o;
    posit_pkg::posit_info_t [NumOperands-1:0] info_o;
    logic [TagWidth-1:0]                   tag_o;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic                                  busy_o;

    modport slave (
        input  operands_i, info_i, tag_i, in_valid_i, out_ready_i,
        output in_ready_o, sign_o, scale_o, mant_o, info_o, tag_o, out_valid_o, busy_o
    );

    modport master (
        output operands_i, info_i, tag_i, in_valid_i, out_ready_i,
        input  in_ready_o, sign_o, scale_o, mant_o, info_o, tag_o, out_valid_o, busy_o
    );

endinterface

// File: rtl/posit_decoder.sv
// Two-stage posit32 (es=2) decoder: S1 takes the magnitude and measures the regime,
// and S2 forms sign, scale and mantissa. The outputs come only from S2 registers.
module posit_decoder #(
    parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
    parameter int NumOperands = 2,
    parameter int TagWidth    = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    posit_decoder_if.slave bus
);

    import posit_pkg::*;

    localparam int EsBits = (pFormat == POSIT32_ES2) ? 2 : 0;

    logic s1Valid_q, s2Valid_q;
    logic s1Load, s2Load;

    logic [NumOperands-1:0][30:0] inMag;
    logic [NumOperands-1:0]       s1Sign_q, s1RegBit_d, s1RegBit_q;
    logic [NumOperands-1:0][4:0]  s1RunLen_d, s1RunLen_q;
    logic [NumOperands-1:0][28:0] s1Body_q;
    posit_info_t [NumOperands-1:0] s1Info_q;
    logic [TagWidth-1:0]          s1Tag_q;

    logic [NumOperands-1:0][28:0] tail;
    logic [NumOperands-1:0][7:0]  kVal;
    logic [NumOperands-1:0]       sign_d, sign_q;
    logic [NumOperands-1:0][7:0]  scale_d, scale_q;
    logic [NumOperands-1:0][27:0] mant_d, mant_q;
    posit_info_t [NumOperands-1:0] info_q;
    logic [TagWidth-1:0]          tag_q;

    // Run length of the bits equal to body[30], scanning toward the LSB.
    function automatic logic [4:0] regimeLength(input logic [30:0] body);
        logic [4:0] len;
        logic       done;
        len  = 5'd0;
        done = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (!done && (body[i] == body[30])) begin
                len = len + 5'd1;
            end else begin
                done = 1'b1;
            end
        end
        return len;
    endfunction

    assign s2Load         = !s2Valid_q || bus.out_ready_i;
    assign s1Load         = !s1Valid_q || s2Load;
    assign bus.in_ready_o = s1Load;

    // Bits 30:0 of the two's complement equal the low bits of the full negation.
    always_comb begin
        inMag      = '0;
        s1RegBit_d = '0;
        s1RunLen_d = '0;
        for (int l = 0; l < NumOperands; l++) begin
            inMag[l]      = bus.operands_i[l][31] ? (~bus.operands_i[l][30:0] + 31'd1)
                                                  : bus.operands_i[l][30:0];
            s1RegBit_d[l] = inMag[l][30];
            s1RunLen_d[l] = regimeLength(inMag[l]);
        end
    end

    // Body bits 30 and 29 are always regime or terminator, so only 28:0 can hold
    // exponent and fraction; shifting by r-1 brings the first of those to the top.
    always_comb begin
        tail    = '0;
        kVal    = '0;
        sign_d  = '0;
        scale_d = '0;
        mant_d  = '0;
        for (int l = 0; l < NumOperands; l++) begin
            tail[l] = s1Body_q[l] << (s1RunLen_q[l] - 5'd1);
            kVal[l] = s1RegBit_q[l] ? ({3'b000, s1RunLen_q[l]} - 8'd1)
                                    : (8'd0 - {3'b000, s1RunLen_q[l]});
            if (!(s1Info_q[l].is_zero || s1Info_q[l].is_NaR)) begin
                sign_d[l]  = s1Sign_q[l];
                scale_d[l] = (kVal[l] << EsBits) + {6'd0, tail[l][28:27]};
                mant_d[l]  = {1'b1, tail[l][26:0]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s1Sign_q   <= '0;
            s1RegBit_q <= '0;
            s1RunLen_q <= '0;
            s1Body_q   <= '0;
            s1Info_q   <= '0;
            s1Tag_q    <= '0;
            sign_q     <= '0;
            scale_q    <= '0;
            mant_q     <= '0;
            info_q     <= '0;
            tag_q      <= '0;
        end else begin
            if (s1Load) begin
                s1Valid_q <= bus.in_valid_i;
                if (bus.in_valid_i) begin
                    for (int l = 0; l < NumOperands; l++) begin
                        s1Sign_q[l] <= bus.operands_i[l][31];
                        s1Body_q[l] <= inMag[l][28:0];
                    end
                    s1RegBit_q <= s1RegBit_d;
                    s1RunLen_q <= s1RunLen_d;
                    s1Info_q   <= bus.info_i;
                    s1Tag_q    <= bus.tag_i;
                end
            end
            if (s2Load) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    sign_q  <= sign_d;
                    scale_q <= scale_d;
                    mant_q  <= mant_d;
                    info_q  <= s1Info_q;
                    tag_q   <= s1Tag_q;
                end
            end
        end
    end

    assign bus.sign_o      = sign_q;
    assign bus.scale_o     = scale_q;
    assign bus.mant_o      = mant_q;
    assign bus.info_o      = info_q;
    assign bus.tag_o       = tag_q;
    assign bus.out_valid_o = s2Valid_q;
    assign bus.busy_o      = s1Valid_q || s2Valid_q;

endmodule

// File: tb/tb_posit_decoder.sv
// Bench for posit_decoder: table of hand-decoded posits, then backpressure, reset
// flush and a random stream checked against a bit-walking reference decoder.
module tb_posit_decoder;

    import posit_pkg::*;

    localparam int NumOps = 2;
    localparam int TagW   = 4;
    localparam int NumVec = 14;

    typedef struct {
        logic [31:0] operand;
        logic        expSign;
        logic [7:0]  expScale;
        logic [27:0] expMant;
    } vec_t;

    typedef struct {
        logic [NumOps-1:0]        sign;
        logic [NumOps-1:0][7:0]   scale;
        logic [NumOps-1:0][27:0]  mant;
        posit_info_t [NumOps-1:0] info;
        logic [TagW-1:0]          tag;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   inCount = 0;
    int   outCount = 0;
    bit   sbOn = 1'b0;
    txn_t expQ[$];
    vec_t vecs[NumVec];

    posit_decoder_if #(.NumOperands(NumOps), .TagWidth(TagW)) dutIf();

    posit_decoder #(
        .pFormat(POSIT32_ES2),
        .NumOperands(NumOps),
        .TagWidth(TagW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(dutIf.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic posit_info_t classify(input logic [31:0] w);
        posit_info_t i;
        i.is_zero = (w == 32'h0);
        i.is_NaR  = (w == 32'h80000000);
        i.is_pos  = !w[31] && (w != 32'h0);
        i.is_neg  = w[31] && (w != 32'h80000000);
        return i;
    endfunction

    // Reference: walk the magnitude bit by bit, reading past the LSB as zero.
    function automatic void refDecode(input logic [31:0] w, input posit_info_t inf,
                                      output logic s, output logic [7:0] sc,
                                      output logic [27:0] m);
        logic [31:0] mag;
        logic        first;
        logic [26:0] frac;
        int          idx, cnt, k, e;
        s = 1'b0; sc = 8'd0; m = 28'd0;
        if (inf.is_zero || inf.is_NaR) return;
        s     = w[31];
        mag   = w[31] ? (~w + 32'd1) : w;
        first = mag[30];
        idx   = 30;
        cnt   = 0;
        while (idx >= 0) begin
            if (mag[idx] != first) break;
            cnt++;
            idx--;
        end
        k = first ? (cnt - 1) : -cnt;
        idx--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((idx >= 0) ? int'(mag[idx]) : 0);
            idx--;
        end
        frac = '0;
        for (int j = 26; j >= 0; j--) begin
            if (idx >= 0) frac[j] = mag[idx];
            idx--;
        end
        sc = 8'(4 * k + e);
        m  = {1'b1, frac};
    endfunction

    function automatic txn_t expectTxn();
        txn_t        t;
        logic        s;
        logic [7:0]  sc;
        logic [27:0] m;
        for (int l = 0; l < NumOps; l++) begin
            refDecode(dutIf.operands_i[l], dutIf.info_i[l], s, sc, m);
            t.sign[l]  = s;
            t.scale[l] = sc;
            t.mant[l]  = m;
            t.info[l]  = dutIf.info_i[l];
        end
        t.tag = dutIf.tag_i;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] op0, input logic [31:0] op1,
                                 input logic [TagW-1:0] tag);
        dutIf.operands_i[0] = op0;
        dutIf.operands_i[1] = op1;
        dutIf.info_i[0]     = classify(op0);
        dutIf.info_i[1]     = classify(op1);
        dutIf.tag_i         = tag;
        dutIf.in_valid_i    = 1'b1;
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 9))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h00000001;
            3:       return 32'h7FFFFFFF;
            4:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: outputs are popped before inputs are pushed in the same cycle.
    always @(negedge clk) begin
        txn_t e;
        if (sbOn) begin
            if (rst) begin
                expQ.delete();
            end else begin
                if (dutIf.out_valid_o && dutIf.out_ready_i) begin
                    outCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected output", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        for (int l = 0; l < NumOps; l++) begin
                            checkOutput($sformatf("stream lane%0d", l),
                                {23'd0, dutIf.info_o[l], dutIf.sign_o[l], dutIf.scale_o[l], dutIf.mant_o[l]},
                                {23'd0, e.info[l], e.sign[l], e.scale[l], e.mant[l]});
                        end
                        checkOutput("stream tag", 64'(dutIf.tag_o), 64'(e.tag));
                    end
                end
                if (dutIf.in_valid_i && dutIf.in_ready_o) begin
                    inCount++;
                    expQ.push_back(expectTxn());
                end
            end
        end
    end

    initial begin
        int outBefore, inBase, outBase, sent, cyc, j;

        vecs[0]  = '{32'h40000000, 1'b0, 8'h00, 28'h8000000};
        vecs[1]  = '{32'h60000001, 1'b0, 8'h04, 28'h8000002};
        vecs[2]  = '{32'h80000001, 1'b1, 8'h78, 28'h8000000};
        vecs[3]  = '{32'hFFFFFFFF, 1'b1, 8'h88, 28'h8000000};
        vecs[4]  = '{32'h00000000, 1'b0, 8'h00, 28'h0000000};
        vecs[5]  = '{32'h80000000, 1'b0, 8'h00, 28'h0000000};
        vecs[6]  = '{32'h7FFFFFFF, 1'b0, 8'h78, 28'h8000000};
        vecs[7]  = '{32'h00000001, 1'b0, 8'h88, 28'h8000000};
        vecs[8]  = '{32'h48000000, 1'b0, 8'h01, 28'h8000000};
        vecs[9]  = '{32'h5C000000, 1'b0, 8'h03, 28'hC000000};
        vecs[10] = '{32'h3FFFFFFF, 1'b0, 8'hFF, 28'hFFFFFFF};
        vecs[11] = '{32'hC0000000, 1'b1, 8'h00, 28'h8000000};
        vecs[12] = '{32'h20000000, 1'b0, 8'hFC, 28'h8000000};
        vecs[13] = '{32'h12345678, 1'b0, 8'hF8, 28'hC68ACF0};

        dutIf.operands_i  = '0;
        dutIf.info_i      = '0;
        dutIf.tag_i       = '0;
        dutIf.in_valid_i  = 1'b1;
        dutIf.out_ready_i = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        dutIf.in_valid_i = 1'b0;

        checkOutput("reset out_valid", 64'(dutIf.out_valid_o), 64'd0);
        checkOutput("reset busy", 64'(dutIf.busy_o), 64'd0);
        checkOutput("reset in_ready", 64'(dutIf.in_ready_o), 64'd1);
        checkOutput("reset tag", 64'(dutIf.tag_o), 64'd0);
        checkOutput("reset lanes",
            {dutIf.sign_o, dutIf.scale_o[0], dutIf.scale_o[1], dutIf.info_o},
            64'd0);
        checkOutput("reset mant", {8'd0, dutIf.mant_o}, 64'd0);

        for (int i = 0; i < NumVec; i++) begin
            j = (i + 5) % NumVec;
            applyStimulus(vecs[i].operand, vecs[j].operand, 4'(i));
            step();
            dutIf.in_valid_i = 1'b0;
            step();
            checkOutput($sformatf("vec%0d out_valid", i), 64'(dutIf.out_valid_o), 64'd1);
            checkOutput($sformatf("vec%0d tag", i), 64'(dutIf.tag_o), 64'(i));
            checkOutput($sformatf("vec%0d lane0", i),
                {23'd0, dutIf.info_o[0], dutIf.sign_o[0], dutIf.scale_o[0], dutIf.mant_o[0]},
                {23'd0, classify(vecs[i].operand), vecs[i].expSign, vecs[i].expScale, vecs[i].expMant});
            checkOutput($sformatf("vec%0d lane1", i),
                {23'd0, dutIf.info_o[1], dutIf.sign_o[1], dutIf.scale_o[1], dutIf.mant_o[1]},
                {23'd0, classify(vecs[j].operand), vecs[j].expSign, vecs[j].expScale, vecs[j].expMant});
        end
        step();

        // Backpressure: two transfers fill both stages, the third waits.
        sbOn = 1'b1;
        dutIf.out_ready_i = 1'b0;
        applyStimulus(vecs[0].operand, vecs[1].operand, 4'd5);
        step();
        applyStimulus(vecs[2].operand, vecs[3].operand, 4'd6);
        step();
        applyStimulus(vecs[4].operand, vecs[5].operand, 4'd7);
        checkOutput("bp in_ready low", 64'(dutIf.in_ready_o), 64'd0);
        checkOutput("bp out_valid", 64'(dutIf.out_valid_o), 64'd1);
        checkOutput("bp first tag", 64'(dutIf.tag_o), 64'd5);
        step();
        step();
        checkOutput("bp hold tag", 64'(dutIf.tag_o), 64'd5);
        checkOutput("bp hold lane0", {28'd0, dutIf.scale_o[0], dutIf.mant_o[0]},
                    {28'd0, vecs[0].expScale, vecs[0].expMant});
        checkOutput("bp hold in_ready", 64'(dutIf.in_ready_o), 64'd0);
        outBefore = outCount;
        dutIf.out_ready_i = 1'b1;
        step();
        dutIf.in_valid_i = 1'b0;
        for (int c = 0; c < 10 && (outCount - outBefore) < 3; c++) step();
        step();
        checkOutput("bp emitted", 64'(outCount - outBefore), 64'd3);
        checkOutput("bp queue empty", 64'(expQ.size()), 64'd0);

        // Reset with both stages full, plus an input offered during reset.
        dutIf.out_ready_i = 1'b0;
        applyStimulus(vecs[6].operand, vecs[7].operand, 4'd10);
        step();
        applyStimulus(vecs[8].operand, vecs[9].operand, 4'd11);
        step();
        checkOutput("flush full busy", 64'(dutIf.busy_o), 64'd1);
        applyStimulus(vecs[10].operand, vecs[11].operand, 4'd12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dutIf.in_valid_i = 1'b0;
        checkOutput("flush out_valid", 64'(dutIf.out_valid_o), 64'd0);
        checkOutput("flush busy", 64'(dutIf.busy_o), 64'd0);
        checkOutput("flush in_ready", 64'(dutIf.in_ready_o), 64'd1);
        checkOutput("flush tag", 64'(dutIf.tag_o), 64'd0);
        checkOutput("flush mant", {8'd0, dutIf.mant_o}, 64'd0);
        outBefore = outCount;
        dutIf.out_ready_i = 1'b1;
        repeat (5) step();
        checkOutput("flush no output", 64'(outCount - outBefore), 64'd0);

        // Random stream with random backpressure.
        inBase  = inCount;
        outBase = outCount;
        sent = 0;
        cyc  = 0;
        while (sent < 150 && cyc < 3000) begin
            if ($urandom_range(0, 3) != 0)
                applyStimulus(randOperand(), randOperand(), 4'($urandom_range(0, 15)));
            else
                dutIf.in_valid_i = 1'b0;
            dutIf.out_ready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (dutIf.in_valid_i && dutIf.in_ready_o) sent++;
            step();
            cyc++;
        end
        dutIf.in_valid_i  = 1'b0;
        dutIf.out_ready_i = 1'b1;
        for (int c = 0; c < 20 && dutIf.busy_o; c++) step();
        step();
        checkOutput("stream sent", 64'(sent), 64'd150);
        checkOutput("stream count", 64'(outCount - outBase), 64'(inCount - inBase));
        checkOutput("stream drained", 64'(expQ.size()), 64'd0);

        sbOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/posit_decoder.md
POSIT_DECODER -- requirements
Module: posit_decoder

Interface
REQ-001 Parameter pFormat, default posit_pkg::posit_format_e'(0) (posit32, es=2), the operand format; this is the only supported value.
REQ-002 Parameter NumOperands, default 2, the number of operands decoded in parallel per transaction.
REQ-003 Parameter TagWidth, default 4, the width of the sideband tag carried with each transaction.
REQ-004 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 operands_i  input  NumOperands x 32  raw posit words.
REQ-007 info_i  input  NumOperands x posit_info_t  classifier flags (is_zero, is_NaR, is_pos, is_neg) for operands_i.
REQ-008 tag_i  input  TagWidth  opaque tag.
REQ-009 in_valid_i  input  1  upstream transaction valid.
REQ-010 in_ready_o  output  1  decoder can accept a transaction this cycle.
REQ-011 sign_o  output  NumOperands x 1  decoded sign.
REQ-012 scale_o  output  NumOperands x 8  signed scale = 4*k + e.
REQ-013 mant_o  output  NumOperands x 28  mantissa: hidden bit at [27], fraction left-aligned in [26:0].
REQ-014 info_o  output  NumOperands x posit_info_t  info_i delayed with its transaction.
REQ-015 tag_o  output  TagWidth  tag_i delayed with its transaction.
REQ-016 out_valid_o  output  1  output transaction valid.
REQ-017 out_ready_i  input  1  downstream accepts the output.
REQ-018 busy_o  output  1  high when either pipeline stage holds a valid transaction.

Function
REQ-019 Two register stages, S1 and S2, each with its own valid bit; outputs are driven only from S2 registers.
- S1 captures the operand magnitude (two's complement when bit31=1), the sign, the regime run length and the regime bit.
- S2 captures sign_o, scale_o, mant_o, info_o and tag_o.
REQ-020 A transfer occurs on a cycle with in_valid_i and in_ready_o both high (input side), or with out_valid_o and out_ready_i both high (output side).
REQ-021 Stage load rules:
- S2 loads when S2 is empty or out_ready_i=1.
- S1 loads when S1 is empty or S2 loads.
- in_ready_o = !S1_valid || S2_load.
- The path from out_ready_i to in_ready_o is combinational.
REQ-022 Latency is 2 cycles from the input transfer to out_valid_o; throughput is 1 transaction per cycle while out_ready_i=1.
REQ-023 While out_valid_o=1 and out_ready_i=0, all S2 outputs hold stable; S1 holds if it is valid.
REQ-024 Decode rules, with mag the magnitude word and body = mag[30:0]:
- The regime is the run of identical bits starting at mag[30], length r (1..31).
- k = r-1 if the run bit is 1, and k = -r otherwise.
- The two exponent bits follow the terminator bit; missing bits read as 0.
- The remaining bits are the fraction, left-aligned into mant_o[26:0] and zero-padded.
- mant_o[27]=1.
REQ-025 scale_o range is -120 (minpos) to +120 (maxpos), represented in 8-bit two's complement with no saturation.
REQ-026 When info_i.is_zero or info_i.is_NaR is set, the lane outputs sign_o=0, scale_o=0 and mant_o=0; info_o still reports the flag.
REQ-027 Lanes decode independently; one lane's special value does not affect other lanes.
REQ-028 A new input transfer in the same cycle as an output transfer is legal and loses no data.

Reset
REQ-029 On a clock edge with rst_i=1, both stage valid bits clear. Starting from the next cycle, out_valid_o=0, busy_o=0 and in_ready_o=1.
REQ-030 Reset mid-operation discards every in-flight transaction; no output transfer follows for those transactions.
REQ-031 After reset, sign_o, scale_o, mant_o, info_o and tag_o read 0.
REQ-032 in_valid_i is ignored during any cycle with rst_i=1.

Verification
REQ-033 Operand 0x40000000, tag 3, out_ready_i=1 -> 2 cycles later: sign 0, scale 0, mant 0x8000000, tag_o 3.
REQ-034 Operand 0x60000001 -> sign 0, scale 4, mant 0x8000002. Operand 0x80000001 -> sign 1, scale 120, mant 0x8000000.
REQ-035 Operand 0xFFFFFFFF -> sign 1, scale -120, mant 0x8000000. Operands 0x00000000 and 0x80000000 -> scale 0 and mant 0, with is_zero and is_NaR respectively passed through.
REQ-036 Backpressure sequence:
- Send 3 back-to-back transactions with out_ready_i=0.
- Required: in_ready_o falls after 2 transfers, and the outputs hold the first transaction.
- Then raise out_ready_i: all 3 transactions emerge in order with no loss or duplication.
REQ-037 Assert rst_i with both stages full -> out_valid_o=0 the next cycle, and the flushed transactions never appear at the outputs.
REQ-038 Random stream with random out_ready_i -> every output matches a reference decoder, in order, with the count of output transfers equal to the count of input transfers.
